// File: rtl/bus_master_port.sv
// Master-side serial bus port: arbitrates, serialises address/write data, collects read data.
// Optional MASTER_PORT_PARITY_EN appends/checks one even-parity bit per serial field.
module bus_master_port #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] M_ADDR,
    input  logic [DATA_W-1:0] M_DIN,
    input  logic              M_RW,
    input  logic              M_EXECUTE,
    input  logic              M_HOLD,
    output logic [DATA_W-1:0] M_DOUT,
    output logic              M_DVALID,
    output logic              M_BSY,
    output logic              M_ERR,
    output logic              B_REQ,
    input  logic              B_GRANT,
    output logic              B_BUS_OUT,
    output logic              B_VALID,
    output logic              B_RW,
    input  logic              B_ACK,
    input  logic              B_BUS_IN,
    input  logic              B_RVALID,
    output logic              B_DONE
);

`ifdef MASTER_PORT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int MAXB  = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;
    localparam int CNT_W = $clog2(MAXB + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W + PB - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W + PB - 1);
    localparam logic [CNT_W-1:0] D_BITS = CNT_W'(DATA_W);
    localparam logic [TMR_W-1:0] T_LAST = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, FINISH, ABORT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] din_sh;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_next;
    logic [DATA_W-1:0] rd_final;
    logic [CNT_W-1:0]  cnt_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              rw_q;
    logic              hold_q;
    logic              tmr_done;
    logic              rd_ok;
    logic              a_bit;
    logic              d_bit;

    assign tmr_done = (tmr_q == T_LAST);
    assign rd_next  = {B_BUS_IN, rd_sh[DATA_W-1:1]};

`ifdef MASTER_PORT_PARITY_EN
    logic par_q;

    // Running XOR of the bits already sent in the current field
    assign a_bit    = (cnt_q == A_LAST) ? par_q : addr_sh[0];
    assign d_bit    = (cnt_q == D_LAST) ? par_q : din_sh[0];
    assign rd_ok    = (B_BUS_IN == ^rd_sh);
    assign rd_final = rd_sh;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            par_q <= 1'b0;
        else if (state_d != state_q)
            par_q <= 1'b0;
        else if (state_q == ADDR)
            par_q <= par_q ^ addr_sh[0];
        else if (state_q == WDATA)
            par_q <= par_q ^ din_sh[0];
    end
`else
    assign a_bit    = addr_sh[0];
    assign d_bit    = din_sh[0];
    assign rd_ok    = 1'b1;
    assign rd_final = rd_next;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (M_EXECUTE)
                    state_d = hold_q ? ADDR : REQ;
            REQ:
                if (B_GRANT)
                    state_d = ADDR;
            ADDR:
                if (cnt_q == A_LAST)
                    state_d = WAIT_ACK;
            WAIT_ACK:
                if (B_ACK)
                    state_d = rw_q ? WDATA : RDATA;
                else if (tmr_done)
                    state_d = ABORT;
            WDATA:
                if (cnt_q == D_LAST)
                    state_d = FINISH;
            RDATA:
                if (B_RVALID) begin
                    if (cnt_q == D_LAST)
                        state_d = rd_ok ? FINISH : ABORT;
                end else if (tmr_done) begin
                    state_d = ABORT;
                end
            FINISH:  state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_sh <= '0;
            din_sh  <= '0;
            rd_sh   <= '0;
            M_DOUT  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            rw_q    <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    hold_q <= hold_q & M_HOLD;
                    if (M_EXECUTE) begin
                        addr_sh <= M_ADDR;
                        din_sh  <= M_DIN;
                        rw_q    <= M_RW;
                    end
                end
                ADDR: begin
                    addr_sh <= addr_sh >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                WAIT_ACK:
                    tmr_q <= tmr_q + TMR_W'(1);
                WDATA: begin
                    din_sh <= din_sh >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                RDATA:
                    if (B_RVALID) begin
                        tmr_q <= '0;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q < D_BITS)
                            rd_sh <= rd_next;
                        if (state_d == FINISH)
                            M_DOUT <= rd_final;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                FINISH:  hold_q <= M_HOLD;
                ABORT:   hold_q <= 1'b0;
                default: ;
            endcase
            // Every state entry starts its bit counter and timer from zero
            if (state_d != state_q) begin
                cnt_q <= '0;
                tmr_q <= '0;
            end
        end
    end

    always_comb begin
        M_BSY     = 1'b0;
        M_ERR     = 1'b0;
        M_DVALID  = 1'b0;
        B_REQ     = 1'b0;
        B_VALID   = 1'b0;
        B_BUS_OUT = 1'b0;
        B_RW      = 1'b0;
        B_DONE    = 1'b0;
        unique case (state_q)
            IDLE:
                B_REQ = hold_q;
            REQ: begin
                M_BSY = 1'b1;
                B_REQ = 1'b1;
            end
            ADDR: begin
                M_BSY     = 1'b1;
                B_REQ     = 1'b1;
                B_RW      = rw_q;
                B_VALID   = 1'b1;
                B_BUS_OUT = a_bit;
            end
            WAIT_ACK, RDATA: begin
                M_BSY = 1'b1;
                B_REQ = 1'b1;
                B_RW  = rw_q;
            end
            WDATA: begin
                M_BSY     = 1'b1;
                B_REQ     = 1'b1;
                B_RW      = rw_q;
                B_VALID   = 1'b1;
                B_BUS_OUT = d_bit;
            end
            FINISH: begin
                M_BSY    = 1'b1;
                B_REQ    = 1'b1;
                B_RW     = rw_q;
                B_DONE   = 1'b1;
                M_DVALID = ~rw_q;
            end
            ABORT: begin
                M_BSY = 1'b1;
                M_ERR = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: vector table of transactions plus
// timeout, hold, mid-transfer reset and (when enabled) parity sequences.
module tb_bus_master_port;

`ifdef MASTER_PORT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] M_ADDR;
    logic [7:0]  M_DIN;
    logic        M_RW;
    logic        M_EXECUTE;
    logic        M_HOLD;
    logic [7:0]  M_DOUT;
    logic        M_DVALID;
    logic        M_BSY;
    logic        M_ERR;
    logic        B_REQ;
    logic        B_GRANT;
    logic        B_BUS_OUT;
    logic        B_VALID;
    logic        B_RW;
    logic        B_ACK;
    logic        B_BUS_IN;
    logic        B_RVALID;
    logic        B_DONE;

    int checks = 0;
    int errors = 0;

    bus_master_port dut (
        .CLK(CLK), .RST(RST),
        .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_RW(M_RW),
        .M_EXECUTE(M_EXECUTE), .M_HOLD(M_HOLD),
        .M_DOUT(M_DOUT), .M_DVALID(M_DVALID), .M_BSY(M_BSY), .M_ERR(M_ERR),
        .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_BUS_OUT(B_BUS_OUT),
        .B_VALID(B_VALID), .B_RW(B_RW), .B_ACK(B_ACK),
        .B_BUS_IN(B_BUS_IN), .B_RVALID(B_RVALID), .B_DONE(B_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  sd;
        int          ack_dly;
        int          gap;
        logic        noise;
        logic [31:0] x_stream;
        int          x_nbits;
        int          x_done;
        int          x_ndv;
        logic [7:0]  x_dout;
    } vec_t;

    typedef struct {
        logic [31:0] stream;
        int          nbits;
        int          done_cyc;
        int          err_cyc;
        int          dv_cyc;
        int          ndv;
        int          nerr;
        int          first_v;
        int          end_cyc;
        logic        req_hi;
        logic        req_end;
        logic [7:0]  dout;
        logic        timed_out;
    } res_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] es(input logic rw, input logic [15:0] a, input logic [7:0] d);
`ifdef MASTER_PORT_PARITY_EN
        return rw ? {7'b0, ^d, d, ^a, a} : {15'b0, ^a, a};
`else
        return rw ? {8'b0, d, a} : {16'b0, a};
`endif
    endfunction

    // Starts in the EXECUTE cycle (t0); models arbiter and slave until M_BSY drops
    task automatic run_txn(
        input logic rw, input logic [15:0] a, input logic [7:0] d, input logic [7:0] sd,
        input int ack_dly, input int gap, input logic hold_in, input logic grant_en,
        input logic noise, input logic bad_par, output res_t r);
        int cyc;
        int w;
        int ph;
        int rb;
        logic acked;
        logic [7:0] tmp;
        r.stream = '0; r.nbits = 0; r.done_cyc = -1; r.err_cyc = -1;
        r.dv_cyc = -1; r.ndv = 0; r.nerr = 0; r.first_v = -1; r.end_cyc = -1;
        r.req_hi = 1'b1; r.req_end = 1'b0; r.dout = '0; r.timed_out = 1'b1;
        M_ADDR = a; M_DIN = d; M_RW = rw; M_HOLD = hold_in; M_EXECUTE = 1'b1;
        B_GRANT = grant_en; B_ACK = 1'b0; B_RVALID = 1'b0; B_BUS_IN = 1'b0;
        tick();
        M_EXECUTE = 1'b0;
        cyc = 1; w = 0; ph = 0; rb = 0; acked = 1'b0;
        while (cyc < 300) begin
            if (!M_BSY) begin
                r.timed_out = 1'b0;
                r.req_end = B_REQ;
                r.end_cyc = cyc;
                r.dout = M_DOUT;
                break;
            end
            if (!B_REQ) r.req_hi = 1'b0;
            if (B_VALID) begin
                if (r.first_v < 0) r.first_v = cyc;
                r.stream = r.stream | (32'(B_BUS_OUT) << r.nbits);
                r.nbits++;
            end
            if (B_DONE) r.done_cyc = cyc;
            if (M_ERR) begin r.err_cyc = cyc; r.nerr++; end
            if (M_DVALID) begin r.dv_cyc = cyc; r.ndv++; end
            B_GRANT = grant_en; B_ACK = 1'b0; B_RVALID = 1'b0; B_BUS_IN = 1'b0;
            if (noise && cyc == 5) begin
                M_EXECUTE = 1'b1; M_ADDR = ~a; M_DIN = ~d; M_RW = ~rw;
            end else begin
                M_EXECUTE = 1'b0;
            end
            if (!acked && !B_VALID && r.nbits == 16 + PB && !M_ERR) begin
                if (w == ack_dly) begin B_ACK = 1'b1; acked = 1'b1; end
                w++;
            end else if (acked && !rw && rb < 8 + PB) begin
                if (ph % (gap + 1) == gap) begin
                    tmp = sd >> rb;
                    B_RVALID = 1'b1;
                    B_BUS_IN = (rb < 8) ? tmp[0] : (^sd ^ bad_par);
                    rb++;
                end
                ph++;
            end
            tick();
            cyc++;
        end
        M_EXECUTE = 1'b0; B_ACK = 1'b0; B_RVALID = 1'b0; B_BUS_IN = 1'b0;
    endtask

    res_t r;
    logic [31:0] xs;

    initial begin
        tbl[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 0, 0, 1'b0, 32'h00A51234, 24, 27, 0, 8'h00};
        tbl[1] = '{1'b0, 16'h00FF, 8'h00, 8'h3C, 0, 1, 1'b0, 32'h000000FF, 16, 35, 1, 8'h3C};
        tbl[2] = '{1'b1, 16'hFFFF, 8'h00, 8'h00, 3, 0, 1'b1, 32'h0000FFFF, 24, 30, 0, 8'h3C};
        tbl[3] = '{1'b0, 16'h8001, 8'h00, 8'hC3, 2, 0, 1'b0, 32'h00008001, 16, 29, 1, 8'hC3};
        tbl[4] = '{1'b1, 16'h0000, 8'hFF, 8'h00, 0, 0, 1'b0, 32'h00FF0000, 24, 27, 0, 8'hC3};

        RST = 1'b1;
        M_ADDR = '0; M_DIN = '0; M_RW = 1'b0; M_EXECUTE = 1'b0; M_HOLD = 1'b0;
        B_GRANT = 1'b0; B_ACK = 1'b0; B_BUS_IN = 1'b0; B_RVALID = 1'b0;
        #12;
        chk("reset_outputs",
            {M_DOUT, M_DVALID, M_BSY, M_ERR, B_REQ, B_BUS_OUT, B_VALID, B_RW, B_DONE}, '0);
        @(posedge CLK);
        #1 RST = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].rw, tbl[i].addr, tbl[i].din, tbl[i].sd, tbl[i].ack_dly,
                    tbl[i].gap, 1'b0, 1'b1, tbl[i].noise, 1'b0, r);
`ifdef MASTER_PORT_PARITY_EN
            xs = es(tbl[i].rw, tbl[i].addr, tbl[i].din);
`else
            xs = tbl[i].x_stream;
`endif
            chk($sformatf("v%0d_bound", i), r.timed_out, 0);
            chk($sformatf("v%0d_stream", i), r.stream, xs);
            chk($sformatf("v%0d_nbits", i), r.nbits, tbl[i].x_nbits + PB * (tbl[i].rw ? 2 : 1));
            chk($sformatf("v%0d_done", i), r.done_cyc,
                tbl[i].x_done + PB * (tbl[i].rw ? 2 : 2 + tbl[i].gap));
            chk($sformatf("v%0d_ndv", i), r.ndv, tbl[i].x_ndv);
            chk($sformatf("v%0d_dout", i), r.dout, tbl[i].x_dout);
            chk($sformatf("v%0d_nerr", i), r.nerr, 0);
            if (tbl[i].x_ndv != 0)
                chk($sformatf("v%0d_bsy_fall", i), r.end_cyc, r.dv_cyc + 1);
        end

        // No acknowledge: abort after the timeout window
        run_txn(1'b0, 16'h0F0F, 8'h00, 8'h00, 1000, 0, 1'b0, 1'b1, 1'b0, 1'b0, r);
        chk("to_bound", r.timed_out, 0);
        chk("to_nerr", r.nerr, 1);
        chk("to_err_cyc", r.err_cyc, 82 + PB);
        chk("to_no_done", r.done_cyc, -1);
        chk("to_no_dv", r.ndv, 0);
        chk("to_dout_kept", r.dout, 8'hC3);
        chk("to_req_low", r.req_end, 0);
        run_txn(1'b1, 16'h1234, 8'hA5, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, r);
        chk("after_to_done", r.done_cyc, 27 + 2 * PB);
        chk("after_to_stream", r.stream, es(1'b1, 16'h1234, 8'hA5));

        // Held bus: second write skips arbitration
        run_txn(1'b1, 16'hBEEF, 8'h5A, 8'h00, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, r);
        chk("hold1_done", r.done_cyc, 27 + 2 * PB);
        chk("hold1_req_hi", r.req_hi, 1);
        chk("hold1_req_end", r.req_end, 1);
        run_txn(1'b1, 16'h0102, 8'h33, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, r);
        chk("hold2_bound", r.timed_out, 0);
        chk("hold2_first_v", r.first_v, 1);
        chk("hold2_done", r.done_cyc, 26 + 2 * PB);
        chk("hold2_req_hi", r.req_hi, 1);
        chk("hold2_req_end", r.req_end, 1);
        chk("hold2_stream", r.stream, es(1'b1, 16'h0102, 8'h33));
        M_HOLD = 1'b0;
        tick();
        chk("hold_drop_req", B_REQ, 0);

        // Reset in the middle of the write-data phase
        M_ADDR = 16'hCAFE; M_DIN = 8'h77; M_RW = 1'b1; M_EXECUTE = 1'b1;
        B_GRANT = 1'b1; B_ACK = 1'b1;
        tick();
        M_EXECUTE = 1'b0;
        repeat (21) tick();
        chk("mid_in_wdata", B_VALID, 1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_outputs",
            {M_DOUT, M_DVALID, M_BSY, M_ERR, B_REQ, B_BUS_OUT, B_VALID, B_RW, B_DONE}, '0);
        @(posedge CLK);
        #1 RST = 1'b0;
        B_ACK = 1'b0;
        tick();
        run_txn(1'b1, 16'hCAFE, 8'h77, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, r);
        chk("post_rst_done", r.done_cyc, 27 + 2 * PB);
        chk("post_rst_stream", r.stream, es(1'b1, 16'hCAFE, 8'h77));

`ifdef MASTER_PORT_PARITY_EN
        run_txn(1'b0, 16'h00FF, 8'h00, 8'h5A, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, r);
        chk("par_good_dv", r.ndv, 1);
        chk("par_good_dout", r.dout, 8'h5A);
        run_txn(1'b0, 16'h0F00, 8'h00, 8'h11, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, r);
        chk("par_bad_err", r.nerr, 1);
        chk("par_bad_no_dv", r.ndv, 0);
        chk("par_bad_dout", r.dout, 8'h5A);
        run_txn(1'b1, 16'h0001, 8'h00, 8'h00, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, r);
        chk("par_addr1_bit", r.stream[16], 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
